// File: rtl/fft_peak_finder_pkg.sv
// Shared types and constants for the FFT peak finder: bin word layout,
// magnitude type and controller state encoding.
package fft_peak_finder_pkg;
    localparam int N_BINS = 512;
    localparam int BIN_W  = 9;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } fft_word_t;

    typedef logic [31:0]      mag_t;
    typedef logic [BIN_W-1:0] bin_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;
endpackage

// File: rtl/fft_peak_finder_if.sv
// Streaming bin input and peak result bundle between the FFT and the peak finder.
interface fft_peak_finder_if;
    import fft_peak_finder_pkg::*;

    logic        frame_start;
    logic        in_valid;
    logic [31:0] data_in;
    logic        busy;
    logic        result_valid;
    bin_t        peak_bin;
    mag_t        peak_mag;
    logic        no_signal;

    modport master (
        output frame_start, in_valid, data_in,
        input  busy, result_valid, peak_bin, peak_mag, no_signal
    );

    modport slave (
        input  frame_start, in_valid, data_in,
        output busy, result_valid, peak_bin, peak_mag, no_signal
    );
endinterface

// File: rtl/fft_peak_finder_mag_sq.sv
// Two-stage squared-magnitude unit: registered re^2/im^2 products, then the
// registered unsigned sum. Bin index and last-bin flag travel alongside.
module fft_mag_sq
    import fft_peak_finder_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      flush,
    input  logic      in_vld,
    input  fft_word_t in_word,
    input  bin_t      in_bin,
    input  logic      in_last,
    output logic      out_vld,
    output mag_t      out_mag,
    output bin_t      out_bin,
    output logic      out_last
);
    logic [1:0]         vld_pipe_d, vld_pipe_q;
    logic signed [31:0] re_ext, im_ext;
    logic signed [31:0] prod_re_d, prod_re_q, prod_im_d, prod_im_q;
    bin_t               bin2_d, bin2_q, bin3_d, bin3_q;
    logic               last2_d, last2_q, last3_d, last3_q;
    mag_t               mag_d, mag_q;

    always_comb begin
        re_ext     = 32'($signed(in_word.re));
        im_ext     = 32'($signed(in_word.im));
        prod_re_d  = re_ext * re_ext;
        prod_im_d  = im_ext * im_ext;
        bin2_d     = in_bin;
        last2_d    = in_last;
        // Each square is at most 2^30, so the sum peaks at 2^31 and fits unsigned.
        mag_d      = mag_t'(prod_re_q) + mag_t'(prod_im_q);
        bin3_d     = bin2_q;
        last3_d    = last2_q;
        vld_pipe_d = flush ? 2'b00 : {vld_pipe_q[0], in_vld};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe_q <= '0;
            prod_re_q  <= '0;
            prod_im_q  <= '0;
            bin2_q     <= '0;
            last2_q    <= 1'b0;
            mag_q      <= '0;
            bin3_q     <= '0;
            last3_q    <= 1'b0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            prod_re_q  <= prod_re_d;
            prod_im_q  <= prod_im_d;
            bin2_q     <= bin2_d;
            last2_q    <= last2_d;
            mag_q      <= mag_d;
            bin3_q     <= bin3_d;
            last3_q    <= last3_d;
        end
    end

    assign out_vld  = vld_pipe_q[1];
    assign out_mag  = mag_q;
    assign out_bin  = bin3_q;
    assign out_last = last3_q;
endmodule

// File: rtl/fft_peak_finder.sv
// Finds the strongest in-band bin of one FFT frame: frame FSM, bin counter,
// input register, range gate and running-maximum tracker around fft_mag_sq.
module fft_peak_finder #(
    parameter int          N_BINS  = fft_peak_finder_pkg::N_BINS,
    parameter int          MIN_BIN = 1,
    parameter int          MAX_BIN = 255,
    parameter logic [31:0] THRESH  = 32'd4096
) (
    input  logic              clk,
    input  logic              reset,
    fft_peak_finder_if.slave  bus
);
    import fft_peak_finder_pkg::*;

    localparam bin_t LAST_B = bin_t'(N_BINS - 1);
    localparam bin_t MIN_B  = bin_t'(MIN_BIN);
    localparam bin_t MAX_B  = bin_t'(MAX_BIN);

    state_e    state_d, state_q;
    bin_t      cnt_d, cnt_q;
    logic      s1_vld_d, s1_vld_q, s1_last_d, s1_last_q;
    fft_word_t s1_word_d, s1_word_q;
    bin_t      s1_bin_d, s1_bin_q;
    mag_t      max_mag_d, max_mag_q, best_mag;
    bin_t      max_bin_d, max_bin_q, best_bin;
    mag_t      peak_mag_d, peak_mag_q;
    bin_t      peak_bin_d, peak_bin_q;
    logic      no_signal_d, no_signal_q, result_valid_d, result_valid_q;

    logic      start, accept, upd, done;
    bin_t      bin_idx;
    logic      m_vld, m_last;
    mag_t      m_mag;
    bin_t      m_bin;

    fft_mag_sq u_mag_sq (
        .clk      (clk),
        .reset    (reset),
        .flush    (start),
        .in_vld   (s1_vld_q),
        .in_word  (s1_word_q),
        .in_bin   (s1_bin_q),
        .in_last  (s1_last_q),
        .out_vld  (m_vld),
        .out_mag  (m_mag),
        .out_bin  (m_bin),
        .out_last (m_last)
    );

    always_comb begin
        start   = bus.frame_start;
        // A start pulse arms the frame in the same cycle, so its word is bin 0.
        accept  = bus.in_valid && (start || state_q == ST_ACCUM);
        bin_idx = start ? '0 : cnt_q;

        s1_vld_d  = accept;
        s1_word_d = fft_word_t'(bus.data_in);
        s1_bin_d  = bin_idx;
        s1_last_d = (bin_idx == LAST_B);

        cnt_d = cnt_q;
        if (start)       cnt_d = accept ? bin_t'(1) : '0;
        else if (accept) cnt_d = cnt_q + bin_t'(1);

        // Stale words from an aborted frame are flushed; ignore the one in flight.
        upd      = m_vld && !start && (m_bin >= MIN_B) && (m_bin <= MAX_B) && (m_mag > max_mag_q);
        done     = m_vld && !start && m_last;
        best_mag = upd ? m_mag : max_mag_q;
        best_bin = upd ? m_bin : max_bin_q;

        max_mag_d = best_mag;
        max_bin_d = best_bin;
        if (start) begin
            max_mag_d = '0;
            max_bin_d = MIN_B;
        end

        result_valid_d = done;
        peak_mag_d     = peak_mag_q;
        peak_bin_d     = peak_bin_q;
        no_signal_d    = no_signal_q;
        if (done) begin
            peak_mag_d  = best_mag;
            peak_bin_d  = best_bin;
            no_signal_d = (best_mag < THRESH);
        end

        state_d = state_q;
        if (start) begin
            state_d = ST_ACCUM;
        end else begin
            case (state_q)
                ST_ACCUM: if (accept && cnt_q == LAST_B) state_d = ST_DRAIN;
                ST_DRAIN: if (done) state_d = ST_IDLE;
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            s1_vld_q       <= 1'b0;
            s1_word_q      <= '0;
            s1_bin_q       <= '0;
            s1_last_q      <= 1'b0;
            max_mag_q      <= '0;
            max_bin_q      <= MIN_B;
            peak_mag_q     <= '0;
            peak_bin_q     <= '0;
            no_signal_q    <= 1'b1;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            s1_vld_q       <= s1_vld_d;
            s1_word_q      <= s1_word_d;
            s1_bin_q       <= s1_bin_d;
            s1_last_q      <= s1_last_d;
            max_mag_q      <= max_mag_d;
            max_bin_q      <= max_bin_d;
            peak_mag_q     <= peak_mag_d;
            peak_bin_q     <= peak_bin_d;
            no_signal_q    <= no_signal_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.result_valid = result_valid_q;
    assign bus.peak_bin     = peak_bin_q;
    assign bus.peak_mag     = peak_mag_q;
    assign bus.no_signal    = no_signal_q;
endmodule

// File: tb/tb_fft_peak_finder.sv
// Self-checking bench for fft_peak_finder: directed frame table, random frames
// against an argmax reference model, abort and mid-frame reset sequences.
module tb_fft_peak_finder;
    localparam int          NB      = 512;
    localparam int          MIN_BIN = 1;
    localparam int          MAX_BIN = 255;
    localparam logic [31:0] THRESH  = 32'd4096;

    typedef struct {
        string       name;
        int          kind;
        bit          combo;
        int          gap_pct;
        logic [8:0]  ebin;
        logic [31:0] emag;
        logic        ensig;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   rv_count = 0;
    logic [31:0] frame [NB];

    fft_peak_finder_if bus ();

    fft_peak_finder #(
        .N_BINS  (NB),
        .MIN_BIN (MIN_BIN),
        .MAX_BIN (MAX_BIN),
        .THRESH  (THRESH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.result_valid === 1'b1) rv_count <= rv_count + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: argmax of re^2+im^2 over the searched range, lowest bin on ties.
    task automatic model(output logic [8:0] b, output logic [31:0] m, output logic ns);
        longint best = 0;
        int     bb   = MIN_BIN;
        for (int k = MIN_BIN; k <= MAX_BIN; k++) begin
            logic [31:0] w  = frame[k];
            longint      re = longint'($signed(w[31:16]));
            longint      im = longint'($signed(w[15:0]));
            longint      mm = re * re + im * im;
            if (mm > best) begin
                best = mm;
                bb   = k;
            end
        end
        b  = 9'(bb);
        m  = 32'(best);
        ns = (best < longint'(THRESH));
    endtask

    task automatic build(input int kind);
        for (int i = 0; i < NB; i++) frame[i] = 32'h0;
        case (kind)
            0: frame[37] = 32'h4000_0000;
            1: begin frame[10] = 32'h1000_1000; frame[20] = 32'h1000_1000; end
            2: begin frame[0] = 32'h7FFF_0000; frame[300] = 32'h7FFF_0000; frame[5] = 32'h0100_0000; end
            3: for (int i = 0; i < NB; i++) frame[i] = 32'h0010_0010;
            default: frame[3] = 32'h8000_8000;
        endcase
    endtask

    task automatic fill_small(input int amp);
        for (int i = 0; i < NB; i++) begin
            logic [15:0] re = 16'($urandom_range(2 * amp) - amp);
            logic [15:0] im = 16'($urandom_range(2 * amp) - amp);
            frame[i] = {re, im};
        end
    endtask

    // Streams frame[] with optional random gaps, then watches the drain window
    // while junk words keep arriving (they must be ignored).
    task automatic run_frame(input string nm, input bit combo, input int gap_pct);
        int   base;
        logic rv_at [7];
        logic busy0, busy3;
        base = rv_count;
        @(negedge clk);
        bus.frame_start = 1'b1;
        bus.in_valid    = combo;
        bus.data_in     = frame[0];
        @(negedge clk);
        bus.frame_start = 1'b0;
        for (int i = combo ? 1 : 0; i < NB; i++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                bus.in_valid = 1'b0;
                bus.data_in  = $urandom;
                @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.data_in  = frame[i];
            @(negedge clk);
        end
        bus.data_in = 32'h7FFF_7FFF;
        busy0 = bus.busy;
        busy3 = 1'b1;
        for (int k = 0; k < 7; k++) begin
            rv_at[k] = bus.result_valid;
            if (k == 3) busy3 = bus.busy;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk({nm, " busy_drain"}, 32'(busy0), 32'd1);
        chk({nm, " rv_pre"}, 32'({rv_at[0], rv_at[1], rv_at[2]}), 32'd0);
        chk({nm, " rv_at_3"}, 32'(rv_at[3]), 32'd1);
        chk({nm, " rv_count"}, 32'(rv_count - base), 32'd1);
        chk({nm, " busy_idle"}, 32'(busy3), 32'd0);
    endtask

    task automatic feed_partial(input int n);
        @(negedge clk);
        bus.frame_start = 1'b1;
        bus.in_valid    = 1'b0;
        @(negedge clk);
        bus.frame_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.data_in  = (i == 50) ? 32'h7000_7000 : frame[i];
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_peak(input string nm, input logic [8:0] b, input logic [31:0] m, input logic ns);
        chk({nm, " peak_bin"}, 32'(bus.peak_bin), 32'(b));
        chk({nm, " peak_mag"}, bus.peak_mag, m);
        chk({nm, " no_signal"}, 32'(bus.no_signal), 32'(ns));
    endtask

    initial begin
        vec_t        vecs [5];
        logic [8:0]  mb;
        logic [31:0] mm;
        logic        mn;
        int          base;

        vecs[0] = '{"tone",    0, 1'b0, 0,  9'd37, 32'h1000_0000, 1'b0};
        vecs[1] = '{"tie",     1, 1'b1, 0,  9'd10, 32'h0200_0000, 1'b0};
        vecs[2] = '{"range",   2, 1'b1, 20, 9'd5,  32'h0001_0000, 1'b0};
        vecs[3] = '{"silence", 3, 1'b0, 10, 9'd1,  32'h0000_0200, 1'b1};
        vecs[4] = '{"extreme", 4, 1'b0, 0,  9'd3,  32'h8000_0000, 1'b0};

        reset = 1'b1;
        bus.frame_start = 1'b0;
        bus.in_valid    = 1'b0;
        bus.data_in     = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset result_valid", 32'(bus.result_valid), 32'd0);
        chk_peak("reset", 9'd0, 32'd0, 1'b1);
        reset = 1'b0;

        for (int v = 0; v < 5; v++) begin
            build(vecs[v].kind);
            run_frame(vecs[v].name, vecs[v].combo, vecs[v].gap_pct);
            chk_peak(vecs[v].name, vecs[v].ebin, vecs[v].emag, vecs[v].ensig);
        end

        for (int r = 0; r < 4; r++) begin
            if (r < 2) for (int i = 0; i < NB; i++) frame[i] = $urandom;
            else fill_small(r == 2 ? 31 : 200);
            run_frame($sformatf("rand%0d", r), r[0], 15 * r);
            model(mb, mm, mn);
            chk_peak($sformatf("rand%0d", r), mb, mm, mn);
        end

        fill_small(127);
        frame[99] = 32'h2000_2000;
        base = rv_count;
        feed_partial(200);
        run_frame("abort", 1'b0, 25);
        model(mb, mm, mn);
        chk("abort single pulse", 32'(rv_count - base), 32'd1);
        chk("abort bin99", 32'(bus.peak_bin), 32'd99);
        chk_peak("abort", mb, mm, mn);

        base = rv_count;
        feed_partial(100);
        @(negedge clk);
        reset = 1'b1;
        bus.frame_start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.frame_start = 1'b0;
        chk("reset_prio busy", 32'(bus.busy), 32'd0);
        for (int i = 100; i < NB; i++) begin
            bus.in_valid = 1'b1;
            bus.data_in  = frame[i];
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("midreset no pulse", 32'(rv_count - base), 32'd0);
        chk("midreset busy", 32'(bus.busy), 32'd0);
        chk_peak("midreset", 9'd0, 32'd0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fft_peak_finder.md
FFT_PEAK_FINDER -- requirements
Module: fft_peak_finder

Interface
REQ-001 Parameter N_BINS, default 512, is the number of FFT output words per frame.
REQ-002 Parameter MIN_BIN, default 1, is the lowest bin searched; bin 0 (DC) is excluded by default.
REQ-003 Parameter MAX_BIN, default 255, is the highest bin searched; bins above MAX_BIN are mirror bins of real input.
REQ-004 Parameter THRESH, default 32'd4096, is the minimum squared magnitude counted as a signal.
REQ-005 Port clk, input, 1 bit: the single clock; one clock for the whole block.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port frame_start, input, 1 bit: a one-cycle pulse that arms a new frame.
REQ-008 Port in_valid, input, 1 bit: data_in carries the next FFT bin this cycle.
REQ-009 Port data_in, input, 32 bits: {re[31:16], im[15:0]}, each a signed Q1.15 value, from the FFT data_out.
REQ-010 Port busy, output, 1 bit: a frame is armed or draining.
REQ-011 Port result_valid, output, 1 bit: a one-cycle pulse when the peak_* outputs update.
REQ-012 Port peak_bin, output, 9 bits: index of the maximum-magnitude bin.
REQ-013 Port peak_mag, output, 32 bits: unsigned re^2+im^2 of that bin.
REQ-014 Port no_signal, output, 1 bit: peak_mag < THRESH for the latest result.

Function
REQ-015 The block SHALL implement a state machine with three states: IDLE, ACCUM, DRAIN.
- IDLE -> ACCUM on frame_start.
- ACCUM -> DRAIN on the edge that accepts bin N_BINS-1.
- DRAIN -> IDLE after the pipeline empties.
REQ-016 In ACCUM, the block SHALL accept a word on every in_valid=1 edge; the bin counter starts at 0 and increments by 1 per accepted word.
REQ-017 Words presented while in IDLE or DRAIN SHALL be ignored.
REQ-018 The pipeline SHALL have three stages:
- S1 registers data_in and the bin index.
- S2 registers re*re and im*im as signed 32-bit products.
- S3 forms the unsigned 32-bit sum and compares it with the running maximum.
REQ-019 The sum SHALL never overflow; the maximum value is 2^31, at re=im=-32768.
REQ-020 The running maximum SHALL update only on a strictly greater value for bins MIN_BIN..MAX_BIN inclusive, so on ties the lowest bin wins.
REQ-021 The running maximum SHALL clear to magnitude 0, bin MIN_BIN on frame_start.
REQ-022 result_valid SHALL pulse high for exactly 1 cycle, 3 cycles after the edge that accepts bin N_BINS-1.
- On that pulse the block loads peak_bin, peak_mag and no_signal.
- It then returns to IDLE.
REQ-023 peak_bin, peak_mag and no_signal SHALL hold their values until the next result_valid or a reset.
REQ-024 busy SHALL be 1 in ACCUM and DRAIN, and 0 in IDLE.
REQ-025 A frame_start in ACCUM or DRAIN SHALL abort the current frame, clear the counter and the maximum, and stay in or enter ACCUM; no result_valid is produced for the aborted frame.
REQ-026 frame_start and in_valid asserted in the same cycle SHALL arm the frame, and that word SHALL be accepted as bin 0.
REQ-027 Gaps in in_valid SHALL stall counting only; the final result is independent of the gap pattern.

Reset
REQ-028 While reset=1, the block SHALL enter IDLE on the next edge.
- Outputs go to: busy=0, result_valid=0, peak_bin=0, peak_mag=0, no_signal=1.
- The bin counter, pipeline valid bits and running maximum clear.
REQ-029 A reset during ACCUM or DRAIN SHALL discard the frame, with no result_valid pulse.
REQ-030 reset SHALL take priority over frame_start in the same cycle.

Structure
REQ-031 The shared package SHALL hold:
- N_BINS;
- the fft_word_t typedef (packed struct of re and im, signed 16 bits each);
- the mag_t typedef (32-bit unsigned);
- the state enum.
REQ-032 One sub-module, fft_mag_sq, SHALL implement stages S2 and S3 as a registered squared-magnitude unit with a valid in and a valid out.
REQ-033 The top level SHALL contain the FSM, the bin counter, the range gate and the maximum tracker.

Verification
REQ-034 The bench SHALL cover the following directed scenarios:
- Tone: frame with bin 37 = {16'h4000, 16'h0000} and all other bins 0 -> result_valid exactly 3 cycles after bin 511; peak_bin=37, peak_mag=32'h1000_0000, no_signal=0.
- Tie: bins 10 and 20 both = {16'h1000, 16'h1000} -> peak_bin=10, peak_mag=32'h0200_0000.
- Range gate: bin 0 and bin 300 = {16'h7FFF, 0}, bin 5 = {16'h0100, 0} -> peak_bin=5, peak_mag=32'h0001_0000.
- Silence: all bins = {16'h0010, 16'h0010} -> peak_mag=32'h200, no_signal=1, peak_bin=MIN_BIN=1.
- Abort and gaps: frame_start again at bin 200, then a full frame with random in_valid gaps and peak at bin 99 -> exactly one result_valid, peak_bin=99; reset asserted mid-frame -> no pulse, outputs return to reset values.
- Extreme value: bin 3 = {16'h8000, 16'h8000} -> peak_mag=32'h8000_0000, no overflow.
